// File: rtl/ext_mem_model_2ch_if.sv
// Master-port bundle between accelerator and external memory model.
// Signal names follow the accelerator's generated Mout_* port list.
interface ext_mem_model_2ch_if #(
  parameter int ADDR_W = 7
);
  logic [1:0]          Mout_oe_ram;
  logic [1:0]          Mout_we_ram;
  logic [2*ADDR_W-1:0] Mout_addr_ram;
  logic [15:0]         Mout_Wdata_ram;
  logic [7:0]          Mout_data_ram_size;
  logic                ld_we;
  logic [ADDR_W-1:0]   ld_addr;
  logic [7:0]          ld_data;
  logic [15:0]         M_Rdata_ram;
  logic [1:0]          M_DataRdy;
  logic [1:0]          err_both;

  modport master (
    output Mout_oe_ram, Mout_we_ram,
    output Mout_addr_ram, Mout_Wdata_ram,
    output Mout_data_ram_size,
    output ld_we, ld_addr, ld_data,
    input  M_Rdata_ram, M_DataRdy, err_both
  );

  modport slave (
    input  Mout_oe_ram, Mout_we_ram,
    input  Mout_addr_ram, Mout_Wdata_ram,
    input  Mout_data_ram_size,
    input  ld_we, ld_addr, ld_data,
    output M_Rdata_ram, M_DataRdy, err_both
  );
endinterface

// File: rtl/ext_mem_model_2ch.sv
// Dual-channel windowed byte memory with read/write latency,
// masked writes, per-channel ready pulses and a preload port.
module ext_mem_model_2ch #(
  parameter int ADDR_W      = 7,
  parameter int BASE_ADDR   = 0,
  parameter int MEM_BYTES   = 64,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1
) (
  input logic               clock,
  input logic               reset,
  ext_mem_model_2ch_if.slave bus
);
  localparam int IW =
    (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int MX =
    (READ_DELAY > WRITE_DELAY) ?
    READ_DELAY : WRITE_DELAY;
  localparam int CW = $clog2(MX + 1);
  localparam int PS = READ_DELAY - 1;

  logic [7:0]    mem_q [MEM_BYTES];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [7:0]    pipe_q [2][PS];
  logic [1:0]    err_q, err_d;
  logic [1:0]    win, rd_req, wr_req;
  logic [1:0]    rdy, smp, cmt;
  logic [IW-1:0] off [2];
  logic [7:0]    wbyte [2];

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [ADDR_W-1:0] addr;
    logic signed [31:0] rel;
    logic               oe, we;
    logic [3:0]         sz;
    logic [8:0]         m9;
    logic [7:0]         mask, wd;
    logic               rd_last, wr_last;

    assign addr = bus.Mout_addr_ram[c*ADDR_W +: ADDR_W];
    assign oe   = bus.Mout_oe_ram[c];
    assign we   = bus.Mout_we_ram[c];
    assign sz   = bus.Mout_data_ram_size[c*4 +: 4];
    assign wd   = bus.Mout_Wdata_ram[c*8 +: 8];

    // Signed offset so BASE_ADDR=0 needs no special case.
    assign rel =
      $signed({{(32-ADDR_W){1'b0}}, addr}) - BASE_ADDR;
    assign win[c] =
      reset & (rel >= 0) & (rel < MEM_BYTES);
    assign off[c] = rel[IW-1:0];

    assign rd_req[c] = oe & ~we & win[c];
    assign wr_req[c] = we & ~oe & win[c];
    assign rd_last =
      cnt_q[c] == CW'(READ_DELAY - 1);
    assign wr_last =
      cnt_q[c] == CW'(WRITE_DELAY - 1);

    assign rdy[c] = (rd_req[c] & rd_last) |
                    (wr_req[c] & wr_last);
    assign smp[c] = rd_req[c] & (cnt_q[c] == '0);
    assign cmt[c] = wr_req[c] & wr_last;

    always_comb begin
      cnt_d[c] = '0;
      if (rd_req[c])
        cnt_d[c] = rd_last ? '0 : cnt_q[c] + CW'(1);
      else if (wr_req[c])
        cnt_d[c] = wr_last ? '0 : cnt_q[c] + CW'(1);
    end

    assign m9   = (9'd1 << sz) - 9'd1;
    assign mask = (sz >= 4'd8) ? 8'hFF : m9[7:0];
    assign wbyte[c] =
      (wd & mask) | (mem_q[off[c]] & ~mask);

    assign err_d[c] = err_q[c] | (oe & we);

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt_q[c] <= '0;
        err_q[c] <= 1'b0;
        for (int s = 0; s < PS; s++)
          pipe_q[c][s] <= '0;
      end else begin
        cnt_q[c] <= cnt_d[c];
        err_q[c] <= err_d[c];
        pipe_q[c][0] <= smp[c] ? mem_q[off[c]] : 8'h00;
        for (int s = 1; s < PS; s++)
          pipe_q[c][s] <= pipe_q[c][s-1];
      end
    end

    assign bus.M_Rdata_ram[c*8 +: 8] =
      rdy[c] ? pipe_q[c][PS-1] : 8'h00;
    assign bus.M_DataRdy[c] = rdy[c];
  end

  assign bus.err_both = err_q;

  // Later assignments win: preload < ch0 < ch1.
  always_ff @(posedge clock) begin
    if (bus.ld_we &&
        (32'(bus.ld_addr) < 32'(MEM_BYTES)))
      mem_q[bus.ld_addr[IW-1:0]] <= bus.ld_data;
    for (int c = 0; c < 2; c++)
      if (cmt[c])
        mem_q[off[c]] <= wbyte[c];
  end
endmodule

// File: tb/tb_ext_mem_model_2ch.sv
// Directed bench for ext_mem_model_2ch (base 0 and base 16).
// Inputs change 1ns after posedge; outputs sampled mid-cycle.
module tb_ext_mem_model_2ch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ext_mem_model_2ch_if #(.ADDR_W(7)) bus ();
  ext_mem_model_2ch_if #(.ADDR_W(7)) bus2 ();

  ext_mem_model_2ch #(
    .ADDR_W(7), .BASE_ADDR(0), .MEM_BYTES(64),
    .READ_DELAY(2), .WRITE_DELAY(1)
  ) u_dut (
    .clock(clk), .reset(rst_n), .bus(bus.slave)
  );

  ext_mem_model_2ch #(
    .ADDR_W(7), .BASE_ADDR(16), .MEM_BYTES(64),
    .READ_DELAY(2), .WRITE_DELAY(1)
  ) u_dut2 (
    .clock(clk), .reset(rst_n), .bus(bus2.slave)
  );

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle();
    bus.Mout_oe_ram = '0;
    bus.Mout_we_ram = '0;
    bus.Mout_addr_ram = '0;
    bus.Mout_Wdata_ram = '0;
    bus.Mout_data_ram_size = '0;
    bus.ld_we = 1'b0;
    bus.ld_addr = '0;
    bus.ld_data = '0;
    bus2.Mout_oe_ram = '0;
    bus2.Mout_we_ram = '0;
    bus2.Mout_addr_ram = '0;
    bus2.Mout_Wdata_ram = '0;
    bus2.Mout_data_ram_size = '0;
    bus2.ld_we = 1'b0;
    bus2.ld_addr = '0;
    bus2.ld_data = '0;
  endtask

  task automatic preload(input logic [6:0] a,
                         input logic [7:0] d);
    bus.ld_we = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    tick();
    bus.ld_we = 1'b0;
  endtask

  // Read on DUT0 channel ch; checks request and ready cycles.
  task automatic rd0(input string tag, input int ch,
                     input logic [6:0] a,
                     input logic [7:0] e);
    logic [15:0] ed;
    logic [1:0]  er;
    ed = (ch == 1) ? {e, 8'h00} : {8'h00, e};
    er = (ch == 1) ? 2'b10 : 2'b01;
    bus.Mout_oe_ram = er;
    bus.Mout_addr_ram = (ch == 1) ? {a, 7'd0} : {7'd0, a};
    settle();
    chk({tag, "_rdy0"}, {14'd0, bus.M_DataRdy}, 16'h0);
    tick();
    settle();
    chk({tag, "_rdy"}, {14'd0, bus.M_DataRdy},
        {14'd0, er});
    chk({tag, "_dat"}, bus.M_Rdata_ram, ed);
    idle();
    tick();
  endtask

  initial begin
    idle();
    tick();
    tick();
    settle();
    chk("rst_dat", bus.M_Rdata_ram, 16'h0);
    chk("rst_rdy", {14'd0, bus.M_DataRdy}, 16'h0);
    chk("rst_err", {14'd0, bus.err_both}, 16'h0);
    rst_n = 1'b1;
    tick();

    preload(7'd0, 8'h11);
    preload(7'd1, 8'h22);
    preload(7'd2, 8'h33);
    preload(7'd3, 8'h44);
    preload(7'd64, 8'h99);
    bus2.ld_we = 1'b1;
    bus2.ld_addr = 7'd0;
    bus2.ld_data = 8'h5A;
    tick();
    idle();

    rd0("rd_a2", 0, 7'd2, 8'h33);
    rd0("ld_oob", 0, 7'd0, 8'h11);
    settle();
    chk("idle_rdy", {14'd0, bus.M_DataRdy}, 16'h0);
    chk("idle_dat", bus.M_Rdata_ram, 16'h0);

    bus.Mout_we_ram = 2'b10;
    bus.Mout_addr_ram = {7'd5, 7'd0};
    bus.Mout_Wdata_ram = {8'hAB, 8'h00};
    bus.Mout_data_ram_size = {4'd8, 4'd0};
    settle();
    chk("wr_rdy", {14'd0, bus.M_DataRdy}, 16'h2);
    chk("wr_dat", bus.M_Rdata_ram, 16'h0);
    tick();
    idle();
    rd0("rd_a5", 1, 7'd5, 8'hAB);

    bus.Mout_we_ram = 2'b10;
    bus.Mout_addr_ram = {7'd5, 7'd0};
    bus.Mout_Wdata_ram = {8'hF0, 8'h00};
    bus.Mout_data_ram_size = {4'd4, 4'd0};
    tick();
    idle();
    rd0("mask4", 1, 7'd5, 8'hA0);

    bus.Mout_we_ram = 2'b11;
    bus.Mout_addr_ram = {7'd9, 7'd9};
    bus.Mout_Wdata_ram = {8'h02, 8'h01};
    bus.Mout_data_ram_size = {4'd8, 4'd8};
    settle();
    chk("ww_rdy", {14'd0, bus.M_DataRdy}, 16'h3);
    tick();
    idle();
    rd0("ww_a9", 0, 7'd9, 8'h02);

    bus.Mout_we_ram = 2'b01;
    bus.Mout_oe_ram = 2'b10;
    bus.Mout_addr_ram = {7'd3, 7'd3};
    bus.Mout_Wdata_ram = {8'h00, 8'h55};
    bus.Mout_data_ram_size = {4'd0, 4'd8};
    tick();
    bus.Mout_we_ram = 2'b00;
    settle();
    chk("rw_rdy", {14'd0, bus.M_DataRdy}, 16'h2);
    chk("rw_old", bus.M_Rdata_ram, 16'h4400);
    idle();
    tick();
    rd0("rw_new", 0, 7'd3, 8'h55);

    bus2.Mout_oe_ram = 2'b01;
    bus2.Mout_addr_ram = {7'd0, 7'd10};
    settle();
    chk("b16_lo_rdy0", {14'd0, bus2.M_DataRdy}, 16'h0);
    tick();
    settle();
    chk("b16_lo_rdy1", {14'd0, bus2.M_DataRdy}, 16'h0);
    chk("b16_lo_dat", bus2.M_Rdata_ram, 16'h0);
    bus2.Mout_addr_ram = {7'd0, 7'd16};
    bus2.Mout_oe_ram = 2'b00;
    tick();
    bus2.Mout_oe_ram = 2'b01;
    tick();
    settle();
    chk("b16_rdy", {14'd0, bus2.M_DataRdy}, 16'h1);
    chk("b16_dat", bus2.M_Rdata_ram, 16'h005A);
    idle();
    tick();

    bus.Mout_oe_ram = 2'b01;
    bus.Mout_we_ram = 2'b01;
    bus.Mout_addr_ram = {7'd0, 7'd0};
    bus.Mout_Wdata_ram = {8'h00, 8'hFF};
    bus.Mout_data_ram_size = {4'd0, 4'd8};
    settle();
    chk("both_rdy", {14'd0, bus.M_DataRdy}, 16'h0);
    tick();
    idle();
    settle();
    chk("both_err", {14'd0, bus.err_both}, 16'h1);
    tick();
    tick();
    chk("both_stk", {14'd0, bus.err_both}, 16'h1);
    rd0("both_mem", 0, 7'd0, 8'h11);

    bus.Mout_oe_ram = 2'b01;
    bus.Mout_addr_ram = {7'd0, 7'd1};
    tick();
    rst_n = 1'b0;
    settle();
    chk("mid_rst_rdy", {14'd0, bus.M_DataRdy}, 16'h0);
    chk("mid_rst_dat", bus.M_Rdata_ram, 16'h0);
    chk("mid_rst_err", {14'd0, bus.err_both}, 16'h0);
    idle();
    tick();
    rst_n = 1'b1;
    tick();
    rd0("post_rst", 0, 7'd1, 8'h22);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ext_mem_model_2ch.md
Name: ext_mem_model_2ch

Overview:
- Synthesizable dual-channel byte memory that terminates the accelerator's master memory port (Mout_* side of the generated top), replacing the behavioural memory logic in the simulation bench.
- Serves reads with configurable latency, applies masked byte writes and raises per-channel data-ready pulses.
- Answers only addresses inside its window, so it can sit beside on-chip slaves whose read data and ready signals are OR-combined downstream.
- Includes a preload port for test-vector initialization.

Parameters:
- ADDR_W, 7: per-channel address width.
- BASE_ADDR, 0: first byte address served.
- MEM_BYTES, 64: number of bytes in the array; window is BASE_ADDR <= addr < BASE_ADDR+MEM_BYTES.
- READ_DELAY, 2: cycles from read request to data/ready; legal range is >= 2.
- WRITE_DELAY, 1: cycles a write is held before commit and ready; legal range is >= 1.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- Mout_oe_ram  in  2  per-channel read enable; bit c belongs to channel c.
- Mout_we_ram  in  2  per-channel write enable.
- Mout_addr_ram  in  2*ADDR_W  channel c address in [c*ADDR_W +: ADDR_W].
- Mout_Wdata_ram  in  16  channel c write byte in [c*8 +: 8].
- Mout_data_ram_size  in  8  channel c access size in bits in [c*4 +: 4].
- ld_we  in  1  preload write strobe.
- ld_addr  in  ADDR_W  preload offset; counted from 0, not from BASE_ADDR.
- ld_data  in  8  preload byte.
- M_Rdata_ram  out  16  per-channel read byte; 0 when not valid.
- M_DataRdy  out  2  per-channel one-cycle ready pulse.
- err_both  out  2  sticky flag: oe and we were asserted together on that channel.

Behaviour:
- Reset while reset=0: M_Rdata_ram=0, M_DataRdy=0, err_both=0, counters=0, read pipeline=0. Array contents are not reset and survive reset.
- Reset asserted mid-access: the pending read or write is discarded and no ready pulse is issued.
- Window check: in_win[c] = addr_c in window. The offset used to index the array is addr_c - BASE_ADDR.
- Per-channel counter cnt[c], default branch at each clock edge:
  - oe & ~we & in_win: cnt increments, wrapping to 0 after READ_DELAY-1.
  - we & ~oe & in_win: cnt increments, wrapping to 0 after WRITE_DELAY-1.
  - any other case: cnt is set to 0.
- Ready pulse: M_DataRdy[c] = in_win & ((oe & ~we & cnt==READ_DELAY-1) | (we & ~oe & cnt==WRITE_DELAY-1)). It is combinational from registered cnt and the current inputs.
- Read timing:
  - The byte is sampled on the edge where the request is first seen (cnt==0).
  - It passes through a READ_DELAY-1 stage pipeline.
  - M_Rdata_ram[c] shows it in the same cycle as the ready pulse; it is 0 in every other cycle.
  - With READ_DELAY=2: request in cycle N gives data and ready in cycle N+1, provided the master holds oe and addr through cycle N+1.
- Write mask: mask = (size>=8) ? 8'hFF : (1<<size)-1. Committed value is mem = (wdata & mask) | (mem & ~mask).
- Write commit: on the edge where cnt==WRITE_DELAY-1. With WRITE_DELAY=1 that is the first edge, and the ready pulse is in the same cycle as we.
- Out-of-window access: no commit, no ready pulse, data 0, cnt held at 0.
- oe and we both high on a channel: no access, M_DataRdy[c]=0, cnt set to 0, err_both[c] set to 1 until reset.
- Simultaneous events:
  - Both channels write the same byte on one edge: channel 1 wins.
  - A read and a write to the same byte on one edge (any channels): the read samples the old value.
  - A preload and a channel write to the same byte: the channel write wins.
- Preload: when ld_we=1 and ld_addr < MEM_BYTES, mem[ld_addr] <= ld_data on the edge. Preload has no ready pulse and no mask. ld_addr >= MEM_BYTES is ignored.
- Address or oe change mid-read (before ready): the counter restarts only when oe drops. The master must hold the address; the sampled data stays as captured on the first edge.

Test Plan:
- Preload offsets 0..3 with 8'h11,22,33,44; channel 0 reads addr 2 in cycle N -> cycle N+1: M_DataRdy=2'b01, M_Rdata_ram[7:0]=8'h33; all other cycles 0.
- Channel 1 writes addr 5 with wdata 8'hAB, size 8 -> M_DataRdy[1] high in the same cycle; a later read of addr 5 returns 8'hAB. Then write 8'hF0 with size 4 -> byte becomes 8'hA0.
- Both channels write addr 9 on one edge (ch0 8'h01, ch1 8'h02) -> a read returns 8'h02. Ch0 writes 8'h55 to addr 3 while ch1 reads addr 3 (preloaded 8'h44) -> ch1 gets 8'h44.
- BASE_ADDR=16: read addr 10 -> no ready and data 0; read addr 16 -> returns the byte at offset 0.
- oe and we both high on ch0 -> err_both=2'b01, no ready, memory unchanged, flag stays set until reset.
- Assert reset one cycle after a read request -> no ready pulse; after release, a previously preloaded byte still reads back unchanged.
